imm_alu_sequencer: RTL and testbench
====================================

// Module: imm_alu_sequencer
// PURPOSE
//  Hardwired control sequencer for the bus datapath: drives fetch (T0-T2) and execute (T3-T5) strobes
//  for immediate ALU instructions (addi/andi/ori) with no bench-driven control signals.
//  Generalises the fixed one-cycle T-step scheme with three additions: configurable step dwell,
//  a memory-ready handshake with timeout, and back-to-back issue. Sits beside `datapath`;
//  its outputs connect 1:1 to the datapath control inputs of the same names.
// PARAMETERS
//  OP_W         5   opcode width, equal to IR[31:27]
//  STEP_CYCLES  1   clocks each T-step holds its strobes (>=1)
//  MEM_TIMEOUT  16  max T1 wait for mem_ready, in clocks; 0 = wait forever
// PORTS
//  Clock      in   1     system clock, rising edge
//  clear      in   1     reset; synchronous, active-high
//  run        in   1     level request to execute the next instruction
//  mem_ready  in   1     memory read data valid on Mdatain
//  ir_opcode  in   OP_W  IR[31:27] from datapath
//  PCout,MARin,Read,MDRin,MDRout,IRin,PCin,IncPC  out 1  fetch strobes
//  Gra,Grb,Grc,Rin,Rout,Yin,Cout,Zin,Zlowout      out 1  execute strobes
//  alu_op     out  OP_W  latched opcode during T3..T5, else 0
//  step       out  4     state code (pkg encoding)
//  busy       out  1     high in T0..T5
//  done       out  1     one-cycle pulse on instruction retire
//  illegal    out  1     sticky; unsupported opcode
//  mem_to     out  1     sticky; T1 timeout
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters 0; op_q 0; sticky flags cleared. clear wins over all
//    other inputs. Mid-instruction clear aborts; strobes are 0 from the next edge.
//  - Moore outputs: every strobe is decoded from the registered state only.
//  - IDLE -(run)-> T0: PCout, MARin
//  - T1: Read, MDRin. Leave only when dwell is complete AND mem_ready=1 (sampled on the same edge).
//    If MEM_TIMEOUT>0 and the wait reaches MEM_TIMEOUT clocks: go to FAULT and set mem_to.
//  - T2: MDRout, IRin, PCin, IncPC
//  - T3: Grb, Rout, Yin. op_q <= ir_opcode on entry to T3.
//    Unsupported op_q: go to FAULT at the end of T3 and set illegal.
//  - T4: Cout, Zin; alu_op = op_q
//  - T5: Zlowout, Gra, Rin
//  - DONE: done=1 for one cycle. Next state is T0 if run=1 (back-to-back), else IDLE.
//  - FAULT: all strobes 0; busy=0; remains here until clear.
//  - Dwell: counter 0..STEP_CYCLES-1, reset on every state change. A state advances when the
//    counter reaches STEP_CYCLES-1. Latency per instruction = 6*STEP_CYCLES + T1 wait + 1 (DONE).
//  - Dropping run mid-instruction has no effect; the instruction completes.
//  - Strobes never overlap across steps: exactly one T-state is active per cycle.
// CONFIGURATION
//  IMM_SEQ_RTYPE_EN defined: also accepts R-format add/sub/and/or. In T4 these drive Grc, Rout, Zin
//    (Cout=0); the remaining steps are unchanged.
//  IMM_SEQ_RTYPE_EN undefined: R-format opcodes are illegal and take the FAULT path.
// STRUCTURE
//  - Package imm_seq_pkg: state enum with 4-bit codes (IDLE=0, T0..T5=7..12, DONE=13, FAULT=15);
//    opcode constants ADD=3, SUB=4, AND=9, OR=10, ADDI=11, ANDI=12, ORI=13;
//    control-word struct; function is_supported(op).
//  - Sub-module imm_seq_step_timer: dwell counter and T1 timeout counter; outputs step_end, timeout.
// TESTING
//  1. STEP_CYCLES=1, mem_ready=1, andi r2,r1,5 (IR 0x61080005) -> T0..T5 in 6 cycles, done at
//     cycle 7; alu_op=12 in T4 only.
//  2. STEP_CYCLES=2 -> every strobe high for exactly 2 cycles; done at cycle 13.
//  3. mem_ready low for 5 cycles, MEM_TIMEOUT=16 -> T1 held 5 extra cycles, Read/MDRin stay high;
//     low for 16 cycles -> FAULT, mem_to=1, strobes 0.
//  4. Opcode 3 (add) without IMM_SEQ_RTYPE_EN -> illegal=1 after T3, no Zin asserted;
//     with the macro -> Grc and Zin in T4, done pulses.
//  5. run held high across two ori instructions -> DONE->T0 directly, two done pulses 7 cycles apart.
//  6. clear asserted during T4 -> next edge: step=0, Zin=0, busy=0; sticky flags cleared.

Source files
------------

// File: rtl/imm_seq_pkg.sv
// Package for the immediate-ALU control sequencer.
//   state_e       : 4-bit state codes (IDLE=0, T0..T5=7..12, DONE=13, FAULT=15);
//                   the code is exported on the step output.
//   OP_*          : opcode values as they appear in IR[31:27].
//   ctrl_t        : one bit per datapath control strobe.
//   is_rtype()    : opcode is one of the R-format ALU instructions.
//   is_supported(): opcode can be executed by this sequencer. The R-format
//                   ops are accepted only when IMM_SEQ_RTYPE_EN is defined.
package imm_seq_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_T0    = 4'd7,
    ST_T1    = 4'd8,
    ST_T2    = 4'd9,
    ST_T3    = 4'd10,
    ST_T4    = 4'd11,
    ST_T5    = 4'd12,
    ST_DONE  = 4'd13,
    ST_FAULT = 4'd15
  } state_e;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd9;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd10;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd11;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'd12;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'd13;

  typedef struct packed {
    logic pcout;
    logic marin;
    logic read;
    logic mdrin;
    logic mdrout;
    logic irin;
    logic pcin;
    logic incpc;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic yin;
    logic cout;
    logic zin;
    logic zlowout;
  } ctrl_t;

  function automatic logic is_rtype(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_supported(input logic [OPC_W-1:0] op);
    logic imm_op;
    imm_op = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
`ifdef IMM_SEQ_RTYPE_EN
    return imm_op || is_rtype(op);
`else
    return imm_op;
`endif
  endfunction

endpackage

// File: rtl/imm_alu_sequencer_if.sv
// Interface bundling the sequencer's request inputs and datapath strobes.
//   run, mem_ready, ir_opcode              : into the sequencer
//   PCout..IncPC                           : fetch strobes
//   Gra..Zlowout                           : execute strobes
//   alu_op, step, busy, done, illegal, mem_to : status
// Modports: master = sequencer side, slave = datapath / requester side.
interface imm_alu_sequencer_if #(
  parameter int OP_W = 5
);
  logic            run;
  logic            mem_ready;
  logic [OP_W-1:0] ir_opcode;

  logic PCout, MARin, Read, MDRin, MDRout, IRin, PCin, IncPC;
  logic Gra, Grb, Grc, Rin, Rout, Yin, Cout, Zin, Zlowout;

  logic [OP_W-1:0] alu_op;
  logic [3:0]      step;
  logic            busy;
  logic            done;
  logic            illegal;
  logic            mem_to;

  modport master (
    input  run, mem_ready, ir_opcode,
    output PCout, MARin, Read, MDRin, MDRout, IRin, PCin, IncPC,
    output Gra, Grb, Grc, Rin, Rout, Yin, Cout, Zin, Zlowout,
    output alu_op, step, busy, done, illegal, mem_to
  );

  modport slave (
    output run, mem_ready, ir_opcode,
    input  PCout, MARin, Read, MDRin, MDRout, IRin, PCin, IncPC,
    input  Gra, Grb, Grc, Rin, Rout, Yin, Cout, Zin, Zlowout,
    input  alu_op, step, busy, done, illegal, mem_to
  );

endinterface

// File: rtl/imm_seq_step_timer.sv
// Step timing for the sequencer.
//   Clock, clear : clock and synchronous active-high reset
//   restart      : the state changes on the next edge; both counters restart
//   in_t1        : current state is T1
//   mem_ready    : memory read data valid
//   step_end     : dwell of the current step is complete (counter at STEP_CYCLES-1)
//   timeout      : T1 has waited MEM_TIMEOUT clocks for mem_ready and would
//                  wait again this cycle; never asserted when MEM_TIMEOUT = 0
module imm_seq_step_timer #(
  parameter int STEP_CYCLES = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic Clock,
  input  logic clear,
  input  logic restart,
  input  logic in_t1,
  input  logic mem_ready,
  output logic step_end,
  output logic timeout
);

  localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(STEP_CYCLES - 1);

  logic [DW-1:0] dwell_q;

  // Dwell saturates at its last value so an idle or stalled step keeps step_end high.
  always_ff @(posedge Clock) begin
    if (clear || restart) begin
      dwell_q <= '0;
    end else if (!step_end) begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  assign step_end = (dwell_q == DWELL_LAST);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

      logic [TW-1:0] wait_q;
      logic          stall;

      // Wait clocks are only those after the dwell has finished with no data.
      assign stall = in_t1 && step_end && !mem_ready;

      always_ff @(posedge Clock) begin
        if (clear || restart) begin
          wait_q <= '0;
        end else if (stall) begin
          wait_q <= wait_q + TW'(1);
        end
      end

      assign timeout = stall && (wait_q == WAIT_LAST);
    end else begin : g_no_timeout
      logic unused_timeout_inputs;
      assign unused_timeout_inputs = &{1'b0, in_t1, mem_ready};
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/imm_alu_sequencer.sv
// Hardwired control sequencer for immediate ALU instructions (addi/andi/ori).
// Fetch T0..T2, execute T3..T5, then a one-cycle DONE. Each T-step holds its
// strobes for STEP_CYCLES clocks; T1 additionally waits for mem_ready, with an
// optional MEM_TIMEOUT that ends in FAULT. DONE chains straight into T0 while
// run stays high.
// Ports:
//   Clock : system clock, rising edge
//   clear : synchronous active-high reset; overrides every other input
//   bus   : imm_alu_sequencer_if.master (run, mem_ready, ir_opcode in;
//           datapath strobes, alu_op, step, busy, done, illegal, mem_to out)
// Build option: IMM_SEQ_RTYPE_EN also accepts R-format add/sub/and/or, which
// use Grc/Rout/Zin in T4 instead of Cout/Zin.
module imm_alu_sequencer
  import imm_seq_pkg::*;
#(
  parameter int OP_W        = 5,
  parameter int STEP_CYCLES = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                 Clock,
  input logic                 clear,
  imm_alu_sequencer_if.master bus
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            illegal_q, mem_to_q;
  logic            set_illegal, set_mem_to;
  logic            step_end, timeout;
  ctrl_t           ctrl;
  logic [OP_W-1:0] alu_op_c;

  imm_seq_step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .Clock     (Clock),
    .clear     (clear),
    .restart   (state_d != state_q),
    .in_t1     (state_q == ST_T1),
    .mem_ready (bus.mem_ready),
    .step_end  (step_end),
    .timeout   (timeout)
  );

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      mem_to_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T2 && state_d == ST_T3) begin
        op_q <= bus.ir_opcode;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_mem_to)  mem_to_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_mem_to  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_T0;
      ST_T0:   if (step_end) state_d = ST_T1;
      ST_T1: begin
        // mem_ready wins over a timeout landing on the same edge.
        if (step_end && bus.mem_ready) begin
          state_d = ST_T2;
        end else if (timeout) begin
          state_d    = ST_FAULT;
          set_mem_to = 1'b1;
        end
      end
      ST_T2:   if (step_end) state_d = ST_T3;
      ST_T3: begin
        if (step_end) begin
          if (is_supported(OPC_W'(op_q))) begin
            state_d = ST_T4;
          end else begin
            state_d     = ST_FAULT;
            set_illegal = 1'b1;
          end
        end
      end
      ST_T4:    if (step_end) state_d = ST_T5;
      ST_T5:    if (step_end) state_d = ST_DONE;
      ST_DONE:  state_d = bus.run ? ST_T0 : ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore decode: strobes depend on the registered state only.
  always_comb begin
    ctrl     = '0;
    alu_op_c = '0;
    unique case (state_q)
      ST_T0: begin ctrl.pcout = 1'b1; ctrl.marin = 1'b1; end
      ST_T1: begin ctrl.read = 1'b1; ctrl.mdrin = 1'b1; end
      ST_T2: begin
        ctrl.mdrout = 1'b1; ctrl.irin = 1'b1; ctrl.pcin = 1'b1; ctrl.incpc = 1'b1;
      end
      ST_T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1; end
      ST_T4: begin
`ifdef IMM_SEQ_RTYPE_EN
        if (is_rtype(OPC_W'(op_q))) begin
          ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1;
        end else begin
          ctrl.cout = 1'b1; ctrl.zin = 1'b1;
        end
`else
        ctrl.cout = 1'b1; ctrl.zin = 1'b1;
`endif
        alu_op_c = op_q;
      end
      ST_T5: begin ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
      default: begin end
    endcase
  end

  assign bus.PCout   = ctrl.pcout;
  assign bus.MARin   = ctrl.marin;
  assign bus.Read    = ctrl.read;
  assign bus.MDRin   = ctrl.mdrin;
  assign bus.MDRout  = ctrl.mdrout;
  assign bus.IRin    = ctrl.irin;
  assign bus.PCin    = ctrl.pcin;
  assign bus.IncPC   = ctrl.incpc;
  assign bus.Gra     = ctrl.gra;
  assign bus.Grb     = ctrl.grb;
  assign bus.Grc     = ctrl.grc;
  assign bus.Rin     = ctrl.rin;
  assign bus.Rout    = ctrl.rout;
  assign bus.Yin     = ctrl.yin;
  assign bus.Cout    = ctrl.cout;
  assign bus.Zin     = ctrl.zin;
  assign bus.Zlowout = ctrl.zlowout;

  assign bus.alu_op  = alu_op_c;
  assign bus.step    = state_q;
  assign bus.busy    = (state_q == ST_T0) || (state_q == ST_T1) || (state_q == ST_T2) ||
                       (state_q == ST_T3) || (state_q == ST_T4) || (state_q == ST_T5);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.illegal = illegal_q;
  assign bus.mem_to  = mem_to_q;

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// Testbench for imm_alu_sequencer: dut1 with STEP_CYCLES=1, dut2 with
// STEP_CYCLES=2, both MEM_TIMEOUT=16. Stimulus pushes the expected output
// record of every presented cycle into a per-DUT queue; a monitor pops and
// compares whenever a DUT is busy, pulses done, or changes step.
module tb_imm_alu_sequencer;

  typedef struct packed {
    logic [3:0]  step;
    logic [16:0] strb;
    logic [4:0]  alu;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        mem_to;
  } rec_t;

  // Strobe bit positions: PCout is the MSB, Zlowout the LSB.
  localparam logic [16:0] S_PCOUT   = 17'd1 << 16;
  localparam logic [16:0] S_MARIN   = 17'd1 << 15;
  localparam logic [16:0] S_READ    = 17'd1 << 14;
  localparam logic [16:0] S_MDRIN   = 17'd1 << 13;
  localparam logic [16:0] S_MDROUT  = 17'd1 << 12;
  localparam logic [16:0] S_IRIN    = 17'd1 << 11;
  localparam logic [16:0] S_PCIN    = 17'd1 << 10;
  localparam logic [16:0] S_INCPC   = 17'd1 << 9;
  localparam logic [16:0] S_GRA     = 17'd1 << 8;
  localparam logic [16:0] S_GRB     = 17'd1 << 7;
  localparam logic [16:0] S_GRC     = 17'd1 << 6;
  localparam logic [16:0] S_RIN     = 17'd1 << 5;
  localparam logic [16:0] S_ROUT    = 17'd1 << 4;
  localparam logic [16:0] S_YIN     = 17'd1 << 3;
  localparam logic [16:0] S_COUT    = 17'd1 << 2;
  localparam logic [16:0] S_ZIN     = 17'd1 << 1;
  localparam logic [16:0] S_ZLOWOUT = 17'd1;

  localparam logic [16:0] E_T0  = S_PCOUT | S_MARIN;
  localparam logic [16:0] E_T1  = S_READ | S_MDRIN;
  localparam logic [16:0] E_T2  = S_MDROUT | S_IRIN | S_PCIN | S_INCPC;
  localparam logic [16:0] E_T3  = S_GRB | S_ROUT | S_YIN;
  localparam logic [16:0] E_T4I = S_COUT | S_ZIN;
  localparam logic [16:0] E_T4R = S_GRC | S_ROUT | S_ZIN;
  localparam logic [16:0] E_T5  = S_ZLOWOUT | S_GRA | S_RIN;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic clear1, clear2;
  int   cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  imm_alu_sequencer_if #(.OP_W(5)) bus1 ();
  imm_alu_sequencer_if #(.OP_W(5)) bus2 ();

  imm_alu_sequencer #(.OP_W(5), .STEP_CYCLES(1), .MEM_TIMEOUT(16)) dut1 (
    .Clock (Clock), .clear (clear1), .bus (bus1)
  );
  imm_alu_sequencer #(.OP_W(5), .STEP_CYCLES(2), .MEM_TIMEOUT(16)) dut2 (
    .Clock (Clock), .clear (clear2), .bus (bus2)
  );

  rec_t obs1, obs2;
  assign obs1 = {bus1.step, bus1.PCout, bus1.MARin, bus1.Read, bus1.MDRin, bus1.MDRout,
                 bus1.IRin, bus1.PCin, bus1.IncPC, bus1.Gra, bus1.Grb, bus1.Grc, bus1.Rin,
                 bus1.Rout, bus1.Yin, bus1.Cout, bus1.Zin, bus1.Zlowout, bus1.alu_op,
                 bus1.busy, bus1.done, bus1.illegal, bus1.mem_to};
  assign obs2 = {bus2.step, bus2.PCout, bus2.MARin, bus2.Read, bus2.MDRin, bus2.MDRout,
                 bus2.IRin, bus2.PCin, bus2.IncPC, bus2.Gra, bus2.Grb, bus2.Grc, bus2.Rin,
                 bus2.Rout, bus2.Yin, bus2.Cout, bus2.Zin, bus2.Zlowout, bus2.alu_op,
                 bus2.busy, bus2.done, bus2.illegal, bus2.mem_to};

  rec_t q1[$];
  rec_t q2[$];
  int   errors = 0;
  int   checks = 0;
  int   seq1 = 0;
  int   seq2 = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev1, prev2;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input int w, input logic [3:0] st, input logic [16:0] s,
                      input logic [4:0] a, input logic il, input logic mt, input int n);
    rec_t r;
    r.step    = st;
    r.strb    = s;
    r.alu     = a;
    r.busy    = (st >= 4'd7) && (st <= 4'd12);
    r.done    = (st == 4'd13);
    r.illegal = il;
    r.mem_to  = mt;
    for (int i = 0; i < n; i++) begin
      if (w == 1) q1.push_back(r);
      else        q2.push_back(r);
    end
  endtask

  task automatic push_fetch(input int w, input int n, input int t1n);
    push(w, 4'd7, E_T0, 5'd0, 1'b0, 1'b0, n);
    push(w, 4'd8, E_T1, 5'd0, 1'b0, 1'b0, t1n);
    push(w, 4'd9, E_T2, 5'd0, 1'b0, 1'b0, n);
  endtask

  task automatic push_exec(input int w, input int n, input logic [4:0] op, input bit rtype);
    push(w, 4'd10, E_T3, 5'd0, 1'b0, 1'b0, n);
    push(w, 4'd11, rtype ? E_T4R : E_T4I, op, 1'b0, 1'b0, n);
    push(w, 4'd12, E_T5, 5'd0, 1'b0, 1'b0, n);
    push(w, 4'd13, 17'd0, 5'd0, 1'b0, 1'b0, 1);
  endtask

  task automatic push_idle(input int w);
    push(w, 4'd0, 17'd0, 5'd0, 1'b0, 1'b0, 1);
  endtask

  task automatic check_rec(input int w, input rec_t got);
    rec_t e;
    int   idx;
    checks++;
    if ((w == 1 && q1.size() == 0) || (w == 2 && q2.size() == 0)) begin
      errors++;
      $display("FAIL dut%0d unexpected_output: got step=%0d strb=%h alu=%0d bdim=%b%b%b%b, required no output",
               w, got.step, got.strb, got.alu, got.busy, got.done, got.illegal, got.mem_to);
      return;
    end
    if (w == 1) begin e = q1.pop_front(); idx = seq1++; end
    else        begin e = q2.pop_front(); idx = seq2++; end
    if (got !== e) begin
      errors++;
      $display("FAIL dut%0d rec%0d: got step=%0d strb=%h alu=%0d bdim=%b%b%b%b, required step=%0d strb=%h alu=%0d bdim=%b%b%b%b",
               w, idx, got.step, got.strb, got.alu, got.busy, got.done, got.illegal, got.mem_to,
               e.step, e.strb, e.alu, e.busy, e.done, e.illegal, e.mem_to);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input int w, output int dc, output bit ok);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if ((w == 1 && bus1.done === 1'b1) || (w == 2 && bus2.done === 1'b1)) begin
        dc = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  always @(negedge Clock) begin
    if (mon_en) begin
      if (obs1.busy || obs1.done || obs1.step != prev1) check_rec(1, obs1);
      prev1 = obs1.step;
    end
  end

  always @(negedge Clock) begin
    if (mon_en) begin
      if (obs2.busy || obs2.done || obs2.step != prev2) check_rec(2, obs2);
      prev2 = obs2.step;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d1, d2;
    bit ok;

    clear1 = 1'b1; clear2 = 1'b1;
    bus1.run = 1'b0; bus1.mem_ready = 1'b1; bus1.ir_opcode = 5'd0;
    bus2.run = 1'b0; bus2.mem_ready = 1'b1; bus2.ir_opcode = 5'd0;
    repeat (3) tick();

    check_val("reset_dut1", int'(obs1), 0);
    check_val("reset_dut2", int'(obs2), 0);

    clear1 = 1'b0; clear2 = 1'b0;
    tick();
    prev1  = obs1.step;
    prev2  = obs2.step;
    mon_en = 1'b1;

    // andi r2,r1,5 (IR 0x61080005), single-cycle steps
    bus1.ir_opcode = 5'd12;
    push_fetch(1, 1, 1); push_exec(1, 1, 5'd12, 1'b0); push_idle(1);
    c0 = cyc; bus1.run = 1'b1;
    tick(); bus1.run = 1'b0;
    wait_done(1, d1, ok);
    check_val("andi_done_cycle", ok ? d1 - c0 : -1, 7);
    repeat (3) tick();

    // Same instruction with two-cycle dwell
    bus2.ir_opcode = 5'd12;
    push_fetch(2, 2, 2); push_exec(2, 2, 5'd12, 1'b0); push_idle(2);
    c0 = cyc; bus2.run = 1'b1;
    tick(); bus2.run = 1'b0;
    wait_done(2, d1, ok);
    check_val("dwell2_done_cycle", ok ? d1 - c0 : -1, 13);
    repeat (3) tick();

    // mem_ready low for 5 clocks of T1
    bus1.mem_ready = 1'b0;
    push_fetch(1, 1, 6); push_exec(1, 1, 5'd12, 1'b0); push_idle(1);
    c0 = cyc; bus1.run = 1'b1;
    tick(); bus1.run = 1'b0;
    tick();
    repeat (5) tick();
    bus1.mem_ready = 1'b1;
    wait_done(1, d1, ok);
    check_val("memwait_done_cycle", ok ? d1 - c0 : -1, 12);
    repeat (3) tick();

    // mem_ready low for 16 clocks: timeout into FAULT
    bus1.mem_ready = 1'b0;
    push(1, 4'd7, E_T0, 5'd0, 1'b0, 1'b0, 1);
    push(1, 4'd8, E_T1, 5'd0, 1'b0, 1'b0, 16);
    push(1, 4'd15, 17'd0, 5'd0, 1'b0, 1'b1, 1);
    bus1.run = 1'b1;
    tick(); bus1.run = 1'b0;
    repeat (20) tick();
    check_val("mem_to_sticky", int'(bus1.mem_to), 1);
    bus1.mem_ready = 1'b1;
    push_idle(1);
    clear1 = 1'b1; tick(); clear1 = 1'b0;
    repeat (2) tick();

    // R-format add (opcode 3)
    bus1.ir_opcode = 5'd3;
    push_fetch(1, 1, 1);
`ifdef IMM_SEQ_RTYPE_EN
    push_exec(1, 1, 5'd3, 1'b1); push_idle(1);
`else
    push(1, 4'd10, E_T3, 5'd0, 1'b0, 1'b0, 1);
    push(1, 4'd15, 17'd0, 5'd0, 1'b1, 1'b0, 1);
`endif
    bus1.run = 1'b1;
    tick(); bus1.run = 1'b0;
    repeat (10) tick();
`ifndef IMM_SEQ_RTYPE_EN
    check_val("illegal_sticky", int'(bus1.illegal), 1);
    push_idle(1);
    clear1 = 1'b1; tick(); clear1 = 1'b0;
    repeat (2) tick();
`endif

    // Back-to-back ori with run held high
    bus1.ir_opcode = 5'd13;
    push_fetch(1, 1, 1); push_exec(1, 1, 5'd13, 1'b0);
    push_fetch(1, 1, 1); push_exec(1, 1, 5'd13, 1'b0); push_idle(1);
    c0 = cyc; bus1.run = 1'b1;
    wait_done(1, d1, ok);
    check_val("b2b_first_done", ok ? d1 - c0 : -1, 7);
    tick(); bus1.run = 1'b0;
    wait_done(1, d2, ok);
    check_val("b2b_done_spacing", ok ? d2 - d1 : -1, 7);
    repeat (3) tick();

    // clear during T4, with run also high: clear wins
    bus1.ir_opcode = 5'd12;
    push_fetch(1, 1, 1);
    push(1, 4'd10, E_T3, 5'd0, 1'b0, 1'b0, 1);
    push(1, 4'd11, E_T4I, 5'd12, 1'b0, 1'b0, 1);
    push_idle(1);
    bus1.run = 1'b1;
    tick(); bus1.run = 1'b0;
    repeat (4) tick();
    clear1 = 1'b1; bus1.run = 1'b1;
    tick();
    check_val("clear_step", int'(bus1.step), 0);
    check_val("clear_zin", int'(bus1.Zin), 0);
    check_val("clear_busy", int'(bus1.busy), 0);
    clear1 = 1'b0; bus1.run = 1'b0;
    repeat (4) tick();

    mon_en = 1'b0;
    check_val("dut1_pending_expected", q1.size(), 0);
    check_val("dut2_pending_expected", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
